rvfi_bus_dmem_tracer: RTL and testbench

Passive monitor on the core's data-memory bus (OBI-style request/grant, then response) that produces one RVFI_BUS channel for the data side. Each completed transfer is reported as a single `rvfi_bus_*` beat carrying the address, masks and data, which is the trace consumed by the bus data-read checkers. It holds up to DEPTH outstanding accepted requests in order and pairs each one with its response. It never drives the memory bus.

---
 rtl/rvfi_bus_pkg.sv | 17 +
 rtl/rvfi_bus_pending_fifo.sv | 41 ++++
 rtl/rvfi_bus_dmem_tracer.sv | 67 ++++++
 tb/tb_rvfi_bus_dmem_tracer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rvfi_bus_pkg.sv
// rvfi_bus_pkg: shared widths, pending-entry type and byte-mask helper for the dmem tracer
package rvfi_bus_pkg;
  localparam int RVFI_XLEN = 32;
  localparam int RVFI_BUSLEN = 32;
  localparam int BYTES = RVFI_BUSLEN / 8;
  typedef struct packed {
    logic [RVFI_XLEN-1:0] addr;
    logic we;
    logic [BYTES-1:0] be;
    logic [RVFI_BUSLEN-1:0] wdata;
  } rvfi_bus_pending_t;
  function automatic logic [RVFI_BUSLEN-1:0] byte_mask_expand(input logic [BYTES-1:0] be);
    logic [RVFI_BUSLEN-1:0] m;
    for (int i = 0; i < BYTES; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction
endpackage

// File: rtl/rvfi_bus_pending_fifo.sv
// rvfi_bus_pending_fifo: in-order store of accepted bus requests awaiting their response
module rvfi_bus_pending_fifo import rvfi_bus_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  rvfi_bus_pending_t din,
  output logic full,
  output logic empty,
  output rvfi_bus_pending_t head
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  rvfi_bus_pending_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd];
  // entry storage; contents are don't-care until pushed so no reset is needed
  always_ff @(posedge clock) begin
    if (push) mem[wr] <= din;
  end
  // pointers wrap modulo DEPTH; occupancy moves by push minus pop
  always_ff @(posedge clock) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/rvfi_bus_dmem_tracer.sv
// rvfi_bus_dmem_tracer: passive OBI data-bus monitor emitting one registered RVFI_BUS beat per response
module rvfi_bus_dmem_tracer import rvfi_bus_pkg::*; #(
  parameter int XLEN = RVFI_XLEN,
  parameter int BUSLEN = RVFI_BUSLEN,
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic bus_req,
  input  logic bus_gnt,
  input  logic [XLEN-1:0] bus_addr,
  input  logic bus_we,
  input  logic [BUSLEN/8-1:0] bus_be,
  input  logic [BUSLEN-1:0] bus_wdata,
  input  logic bus_rvalid,
  input  logic [BUSLEN-1:0] bus_rdata,
  input  logic bus_err,
  output logic rvfi_bus_valid,
  output logic rvfi_bus_insn,
  output logic rvfi_bus_data,
  output logic rvfi_bus_fault,
  output logic [XLEN-1:0] rvfi_bus_addr,
  output logic [BUSLEN/8-1:0] rvfi_bus_rmask,
  output logic [BUSLEN/8-1:0] rvfi_bus_wmask,
  output logic [BUSLEN-1:0] rvfi_bus_rdata,
  output logic [BUSLEN-1:0] rvfi_bus_wdata,
  output logic protocol_err
);
  rvfi_bus_pending_t entry, head;
  logic accept, empty, full, pop, push, stray, overflow;
  assign accept = bus_req & bus_gnt;
  // a response with nothing pending cannot be paired, even if a request is accepted alongside it
  assign stray = bus_rvalid & empty;
  assign pop = bus_rvalid & ~empty;
  assign overflow = accept & full & ~pop;
  assign push = accept & ~overflow;
  assign entry = '{addr: bus_addr & ~XLEN'(BUSLEN/8 - 1), we: bus_we, be: bus_be,
                   wdata: bus_wdata & byte_mask_expand(bus_be)};
  assign rvfi_bus_insn = 1'b0;
  assign rvfi_bus_data = rvfi_bus_valid;
  rvfi_bus_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .din(entry),
    .full(full), .empty(empty), .head(head)
  );
  // register the beat formed from the FIFO head; all fields stay zero between beats
  always_ff @(posedge clock) begin
    if (reset) begin
      rvfi_bus_valid <= 1'b0;
      rvfi_bus_fault <= 1'b0;
      rvfi_bus_addr <= '0;
      rvfi_bus_rmask <= '0;
      rvfi_bus_wmask <= '0;
      rvfi_bus_rdata <= '0;
      rvfi_bus_wdata <= '0;
      protocol_err <= 1'b0;
    end else begin
      rvfi_bus_valid <= pop;
      rvfi_bus_fault <= pop & bus_err;
      rvfi_bus_addr <= pop ? head.addr : '0;
      rvfi_bus_rmask <= pop && !head.we ? head.be : '0;
      rvfi_bus_wmask <= pop && head.we ? head.be : '0;
      rvfi_bus_rdata <= pop && !head.we ? bus_rdata & byte_mask_expand(head.be) : '0;
      rvfi_bus_wdata <= pop ? head.wdata : '0;
      protocol_err <= protocol_err | stray | overflow;
    end
  end
endmodule

// File: tb/tb_rvfi_bus_dmem_tracer.sv
// tb_rvfi_bus_dmem_tracer: directed plan plus randomized traffic checked against a queue-based model
module tb_rvfi_bus_dmem_tracer;
  logic clock = 0, reset = 1;
  logic bus_req = 0, bus_gnt = 0, bus_we = 0, bus_rvalid = 0, bus_err = 0;
  logic [31:0] bus_addr = 0, bus_wdata = 0, bus_rdata = 0;
  logic [3:0] bus_be = 0;
  logic rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault, protocol_err;
  logic [31:0] rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_wdata;
  logic [3:0] rvfi_bus_rmask, rvfi_bus_wmask;
  int passed = 0, total = 0;
  typedef struct {
    logic [31:0] addr;
    logic we;
    logic [3:0] be;
    logic [31:0] wdata;
  } req_t;
  req_t q[$];
  logic e_valid, e_fault, e_err = 0;
  logic [31:0] e_addr, e_rdata, e_wdata;
  logic [3:0] e_rmask, e_wmask;

  rvfi_bus_dmem_tracer dut (
    .clock(clock), .reset(reset), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .rvfi_bus_valid(rvfi_bus_valid),
    .rvfi_bus_insn(rvfi_bus_insn), .rvfi_bus_data(rvfi_bus_data), .rvfi_bus_fault(rvfi_bus_fault),
    .rvfi_bus_addr(rvfi_bus_addr), .rvfi_bus_rmask(rvfi_bus_rmask), .rvfi_bus_wmask(rvfi_bus_wmask),
    .rvfi_bus_rdata(rvfi_bus_rdata), .rvfi_bus_wdata(rvfi_bus_wdata), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] keep(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin passed++; end
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all();
    chk("valid", 32'(rvfi_bus_valid), 32'(e_valid));
    chk("insn", 32'(rvfi_bus_insn), 32'd0);
    chk("data", 32'(rvfi_bus_data), 32'(e_valid));
    chk("fault", 32'(rvfi_bus_fault), 32'(e_fault));
    chk("addr", rvfi_bus_addr, e_addr);
    chk("rmask", 32'(rvfi_bus_rmask), 32'(e_rmask));
    chk("wmask", 32'(rvfi_bus_wmask), 32'(e_wmask));
    chk("rdata", rvfi_bus_rdata, e_rdata);
    chk("wdata", rvfi_bus_wdata, e_wdata);
    chk("protocol_err", 32'(protocol_err), 32'(e_err));
  endtask

  // drive one cycle, predict its registered result, clock it and compare everything
  task automatic cyc(input logic rst, input logic req, input logic gnt, input logic [31:0] addr,
                     input logic we, input logic [3:0] be, input logic [31:0] wd,
                     input logic rv, input logic [31:0] rd, input logic er);
    req_t h;
    reset = rst; bus_req = req; bus_gnt = gnt; bus_addr = addr; bus_we = we; bus_be = be;
    bus_wdata = wd; bus_rvalid = rv; bus_rdata = rd; bus_err = er;
    {e_valid, e_fault, e_addr, e_rmask, e_wmask, e_rdata, e_wdata} = '0;
    if (rst) begin
      q.delete();
      e_err = 0;
    end else begin
      if (rv) begin
        if (q.size() == 0) e_err = 1;
        else begin
          h = q.pop_front();
          e_valid = 1;
          e_fault = er;
          e_addr = {h.addr[31:2], 2'b00};
          e_rmask = h.we ? 4'h0 : h.be;
          e_wmask = h.we ? h.be : 4'h0;
          e_rdata = h.we ? 32'h0 : keep(rd, h.be);
          e_wdata = keep(h.wdata, h.be);
        end
      end
      if (req && gnt) begin
        if (q.size() >= 2) e_err = 1;
        else q.push_back('{addr, we, be, wd});
      end
    end
    @(posedge clock);
    #1;
    chk_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    chk("reset_valid", 32'(rvfi_bus_valid), 32'd0);
    chk("reset_perr", 32'(protocol_err), 32'd0);
    // single read: grant, gap, response
    idle();
    cyc(0, 1, 1, 32'h1003, 0, 4'b0110, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hAABBCCDD, 0);
    chk("read_addr", rvfi_bus_addr, 32'h1000);
    chk("read_rmask", 32'(rvfi_bus_rmask), 32'h6);
    chk("read_rdata", rvfi_bus_rdata, 32'h00BBCC00);
    chk("read_wdata", rvfi_bus_wdata, 32'h0);
    idle();
    chk("read_one_beat", 32'(rvfi_bus_valid), 32'd0);
    // single write
    cyc(0, 1, 1, 32'h2000, 1, 4'hF, 32'h12345678, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
    chk("write_wmask", 32'(rvfi_bus_wmask), 32'hF);
    chk("write_wdata", rvfi_bus_wdata, 32'h12345678);
    chk("write_rdata", rvfi_bus_rdata, 32'h0);
    // pipelined reads, back-to-back responses
    cyc(0, 1, 1, 32'h10, 0, 4'hF, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h20, 0, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0);
    chk("pipe_a_addr", rvfi_bus_addr, 32'h10);
    chk("pipe_a_rdata", rvfi_bus_rdata, 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h22, 0);
    chk("pipe_b_addr", rvfi_bus_addr, 32'h20);
    chk("pipe_b_rdata", rvfi_bus_rdata, 32'h22);
    chk("pipe_perr", 32'(protocol_err), 32'd0);
    // accept and response together while full is legal
    cyc(0, 1, 1, 32'h30, 0, 4'h1, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h34, 0, 4'h2, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h38, 1, 4'h4, 32'h00AB0000, 1, 32'h99, 0);
    chk("fullpop_perr", 32'(protocol_err), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h5500, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("fullpop_third_addr", rvfi_bus_addr, 32'h38);
    chk("fullpop_third_wdata", rvfi_bus_wdata, 32'h00AB0000);
    // error response
    cyc(0, 1, 1, 32'h44, 0, 4'h1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 1);
    chk("err_fault", 32'(rvfi_bus_fault), 32'd1);
    chk("err_rmask", 32'(rvfi_bus_rmask), 32'h1);
    // overflow: third request dropped
    cyc(0, 1, 1, 32'h100, 0, 4'hF, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h104, 0, 4'hF, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h108, 0, 4'hF, 0, 0, 0, 0);
    chk("overflow_perr", 32'(protocol_err), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    chk("overflow_second_addr", rvfi_bus_addr, 32'h104);
    idle();
    // stray response after reset
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0);
    chk("stray_valid", 32'(rvfi_bus_valid), 32'd0);
    chk("stray_perr", 32'(protocol_err), 32'd1);
    // accept and response together with an empty FIFO
    do_reset();
    cyc(0, 1, 1, 32'h200, 0, 4'hF, 0, 1, 32'h1, 0);
    chk("samecyc_empty_valid", 32'(rvfi_bus_valid), 32'd0);
    chk("samecyc_empty_perr", 32'(protocol_err), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3C, 0);
    chk("samecyc_empty_kept", rvfi_bus_addr, 32'h200);
    // reset with two entries pending
    do_reset();
    cyc(0, 1, 1, 32'h300, 0, 4'hF, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h304, 0, 4'hF, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h5, 0);
    chk("midreset_valid", 32'(rvfi_bus_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h6, 0);
    chk("midreset_nobeat", 32'(rvfi_bus_valid), 32'd0);
    chk("midreset_perr", 32'(protocol_err), 32'd1);
    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic rv;
      rv = q.size() != 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 49) == 0;
      cyc($urandom_range(0, 149) == 0, 1'($urandom), $urandom_range(0, 2) != 0, $urandom,
          1'($urandom), 4'($urandom), $urandom, rv, $urandom, $urandom_range(0, 9) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
